// File: rtl/vga_timing_generator.sv
// vga_timing_generator: 640x480@60 raster timing with pixel tick, scan counters and pin-aligned sync/video flags
module vga_timing_generator #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
  output logic [10:0] oCol,
  output logic [10:0] oRow,
  output logic        oPixelTick,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oVideoOn,
  output logic        oFrameStart
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [DW-1:0] div_q, div_d;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic hs_q, hs_d, vs_q, vs_d, von_q, von_d, fs_q, fs_d;
  logic tick, line_end, frame_end;
  always_comb begin
    tick = iEnable & (div_q == DIV_LAST);
    line_end = col_q == H_LAST;
    frame_end = line_end & (row_q == V_LAST);
    div_d = iEnable ? (tick ? '0 : div_q + 1'b1) : div_q;
    col_d = tick ? (line_end ? '0 : col_q + 11'd1) : col_q;
    row_d = (tick & line_end) ? (frame_end ? '0 : row_q + 11'd1) : row_q;
    // Sync/video are decoded from the counters and registered so the pins line up with the compositor's RGB register.
    hs_d = iEnable ? ((col_q >= HS_BEG && col_q < HS_END) ? SYNC_POL : ~SYNC_POL) : hs_q;
    vs_d = iEnable ? ((row_q >= VS_BEG && row_q < VS_END) ? SYNC_POL : ~SYNC_POL) : vs_q;
    von_d = iEnable ? (col_q < H_VIS && row_q < V_VIS) : von_q;
    fs_d = tick & frame_end;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      div_q <= '0;
      col_q <= '0;
      row_q <= '0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      von_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      row_q <= row_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      von_q <= von_d;
      fs_q <= fs_d;
    end
  assign oCol = col_q;
  assign oRow = row_q;
  assign oPixelTick = tick & ~Reset;
  assign oHSync = hs_q;
  assign oVSync = vs_q;
  assign oVideoOn = von_q;
  assign oFrameStart = fs_q & iEnable;
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: directed checks of default, CLK_DIV=1 and reduced-size timing builds
module tb_vga_timing_generator;
  logic Clock = 1'b0, Reset = 1'b1, en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
  logic [10:0] a_col, a_row, b_col, b_row, c_col, c_row;
  logic a_tick, a_hs, a_vs, a_von, a_fs;
  logic b_tick, b_hs, b_vs, b_von, b_fs;
  logic c_tick, c_hs, c_vs, c_von, c_fs;
  int checks = 0, failures = 0;
  int n, bad, prev, r, s_fs, s_vs, s_hs, s_von, s_tick;
  always #5 Clock = ~Clock;
  vga_timing_generator dut_a (
    .Clock(Clock), .Reset(Reset), .iEnable(en_a), .oCol(a_col), .oRow(a_row), .oPixelTick(a_tick),
    .oHSync(a_hs), .oVSync(a_vs), .oVideoOn(a_von), .oFrameStart(a_fs)
  );
  vga_timing_generator #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .iEnable(en_b), .oCol(b_col), .oRow(b_row), .oPixelTick(b_tick),
    .oHSync(b_hs), .oVSync(b_vs), .oVideoOn(b_von), .oFrameStart(b_fs)
  );
  vga_timing_generator #(.CLK_DIV(1)) dut_c (
    .Clock(Clock), .Reset(Reset), .iEnable(en_c), .oCol(c_col), .oRow(c_row), .oPixelTick(c_tick),
    .oHSync(c_hs), .oVSync(c_vs), .oVideoOn(c_von), .oFrameStart(c_fs)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge Clock);
    chk("rst_col", 32'(a_col), 0);
    chk("rst_row", 32'(a_row), 0);
    chk("rst_tick", 32'(a_tick), 0);
    chk("rst_hs", 32'(a_hs), 1);
    chk("rst_vs", 32'(a_vs), 1);
    chk("rst_von", 32'(a_von), 0);
    chk("rst_fs", 32'(a_fs), 0);
    chk("rst_b_hs_pol", 32'(b_hs), 0);
    chk("rst_b_tick", 32'(b_tick), 0);
    Reset = 1'b0;
    #1 chk("rel_tick0", 32'(a_tick), 0);
    @(negedge Clock);
    chk("rel_tick1", 32'(a_tick), 1);
    chk("rel_col_hold", 32'(a_col), 0);
    chk("rel_von", 32'(a_von), 1);
    chk("rel_hs", 32'(a_hs), 1);
    @(negedge Clock);
    chk("rel_col1", 32'(a_col), 1);
    chk("rel_tick2", 32'(a_tick), 0);
    chk("c_col2", 32'(c_col), 2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n += 32'(a_tick);
      @(negedge Clock);
    end
    chk("tick_period", n, 10);
    for (int i = 0; i < 2000 && a_col != 11'd656; i++) @(negedge Clock);
    chk("hs_reach", 32'(a_col), 656);
    chk("hs_lag", 32'(a_hs), 1);
    @(negedge Clock);
    n = 0;
    for (int i = 0; i < 2000 && a_hs == 1'b0; i++) begin
      n++;
      @(negedge Clock);
    end
    chk("hs_width", n, 192);
    prev = 0;
    for (int i = 0; i < 2000 && a_row != 11'd1; i++) begin
      prev = 32'(a_col);
      @(negedge Clock);
    end
    chk("row_inc_prev", prev, 799);
    chk("row_inc_col", 32'(a_col), 0);
    chk("row_inc_row", 32'(a_row), 1);
    n = 0;
    for (int i = 0; i < 4000 && a_row != 11'd2; i++) begin
      @(negedge Clock);
      n++;
    end
    chk("line_period", n, 1600);
    chk("vs_idle", 32'(a_vs), 1);
    for (int i = 0; i < 2000 && a_col != 11'd700; i++) @(negedge Clock);
    chk("dis_reach", 32'(a_col), 700);
    en_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (a_tick !== 1'b0 || a_col !== 11'd700 || a_row !== 11'd2 || a_hs !== 1'b0 || a_von !== 1'b0 || a_fs !== 1'b0) bad++;
      @(negedge Clock);
    end
    chk("dis_frozen", bad, 0);
    en_a = 1'b1;
    #1 chk("res_tick0", 32'(a_tick), 0);
    @(negedge Clock);
    chk("res_tick1", 32'(a_tick), 1);
    chk("res_col700", 32'(a_col), 700);
    @(negedge Clock);
    chk("res_col701", 32'(a_col), 701);
    for (int i = 0; i < 1000 && c_col != 11'd656; i++) @(negedge Clock);
    chk("c_hs_reach", 32'(c_col), 656);
    @(negedge Clock);
    n = 0;
    for (int i = 0; i < 1000 && c_hs == 1'b0; i++) begin
      n++;
      @(negedge Clock);
    end
    chk("c_hs_width", n, 96);
    r = 32'(c_row);
    for (int i = 0; i < 1000 && 32'(c_row) == r; i++) @(negedge Clock);
    r = 32'(c_row);
    n = 0;
    for (int i = 0; i < 1000 && 32'(c_row) == r; i++) begin
      @(negedge Clock);
      n++;
    end
    chk("c_line_period", n, 800);
    for (int i = 0; i < 1000 && b_fs != 1'b1; i++) @(negedge Clock);
    chk("b_fs_seen", 32'(b_fs), 1);
    chk("b_fs_col", 32'(b_col), 0);
    chk("b_fs_row", 32'(b_row), 0);
    s_fs = 0; s_vs = 0; s_hs = 0; s_von = 0; s_tick = 0;
    for (int i = 0; i < 336; i++) begin
      s_fs += 32'(b_fs);
      s_vs += 32'(b_vs);
      s_hs += 32'(b_hs);
      s_von += 32'(b_von);
      s_tick += 32'(b_tick);
      @(negedge Clock);
    end
    chk("b_frame_fs", s_fs, 1);
    chk("b_frame_vs", s_vs, 48);
    chk("b_frame_hs", s_hs, 56);
    chk("b_frame_von", s_von, 128);
    chk("b_frame_tick", s_tick, 336);
    chk("b_frame_period", 32'(b_fs), 1);
    for (int i = 0; i < 400 && !(b_row == 11'd5 && b_hs == 1'b1); i++) @(negedge Clock);
    chk("mid_reach", 32'({b_row, b_hs}), 32'({11'd5, 1'b1}));
    Reset = 1'b1;
    #1;
    chk("mid_col", 32'(b_col), 0);
    chk("mid_row", 32'(b_row), 0);
    chk("mid_hs", 32'(b_hs), 0);
    chk("mid_vs", 32'(b_vs), 0);
    chk("mid_von", 32'(b_von), 0);
    chk("mid_tick", 32'(b_tick), 0);
    chk("mid_a_col", 32'(a_col), 0);
    repeat (3) @(negedge Clock);
    chk("mid_fs_hold", 32'(b_fs), 0);
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 335; i++) begin
      @(negedge Clock);
      n += 32'(b_fs);
    end
    chk("post_rst_no_fs", n, 0);
    @(negedge Clock);
    chk("post_rst_first_fs", 32'(b_fs), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
